// File: rtl/moving_average_collector.sv
// Moving-average filter result collector: show-ahead FIFO with drop
// accounting and running min/max of accepted results.
module moving_average_collector #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               clear,
    input  logic signed [15:0] din,
    input  logic               din_pulse,
    output logic signed [15:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [AW:0]        fifo_level,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    output logic signed [15:0] min_val,
    output logic signed [15:0] max_val
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic signed [15:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               seen_first;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    assign dout_valid = (fifo_level != '0);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full = (fifo_level == FULL);
        pop  = dout_valid && dout_ready && !clear;
        push = enable && din_pulse && !clear && (!full || pop);
        drop = enable && din_pulse && !clear && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                push && !pop: fifo_level <= fifo_level + 1'b1;
                pop && !push: fifo_level <= fifo_level - 1'b1;
                default:      fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_first <= 1'b0;
            min_val    <= '0;
            max_val    <= '0;
        end else if (clear) begin
            seen_first <= 1'b0;
            min_val    <= '0;
            max_val    <= '0;
        end else if (push) begin
            seen_first <= 1'b1;
            if (!seen_first) begin
                min_val <= din;
                max_val <= din;
            end else begin
                if (din < min_val) begin
                    min_val <= din;
                end
                if (din > max_val) begin
                    max_val <= din;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_average_collector.sv
// Randomized bench for moving_average_collector with a queue-based
// reference model and hand-computed anchor checks.
module tb_moving_average_collector;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               clear;
    logic signed [15:0] din;
    logic               din_pulse;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [AW:0]        fifo_level;
    logic               overflow;
    logic [7:0]         drop_cnt;
    logic signed [15:0] min_val;
    logic signed [15:0] max_val;

    int vectors = 0;
    int miscompares = 0;

    moving_average_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .din       (din),
        .din_pulse (din_pulse),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .min_val   (min_val),
        .max_val   (max_val)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic signed [15:0] q[$];
    bit                 m_ovf;
    int                 m_drops;
    bit                 m_seen;
    int                 m_min;
    int                 m_max;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        m_seen  = 1'b0;
        m_min   = 0;
        m_max   = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            if (clear) begin
                model_reset();
            end else begin
                bit pop_c;
                bit push_c;
                bit drop_c;
                pop_c  = (q.size() > 0) && dout_ready;
                push_c = enable && din_pulse && (q.size() < DEPTH || pop_c);
                drop_c = enable && din_pulse && !push_c;
                if (pop_c) void'(q.pop_front());
                if (push_c) begin
                    q.push_back(din);
                    if (!m_seen) begin
                        m_min = din;
                        m_max = din;
                    end else begin
                        if (int'(din) < m_min) m_min = din;
                        if (int'(din) > m_max) m_max = din;
                    end
                    m_seen = 1'b1;
                end
                if (drop_c) begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        #1;
        check("level", int'(fifo_level), q.size());
        check("valid", int'(dout_valid), int'(q.size() > 0));
        check("dout", int'(dout), (q.size() > 0) ? int'(q[0]) : 0);
        check("overflow", int'(overflow), int'(m_ovf));
        check("drop_cnt", int'(drop_cnt), m_drops);
        check("min_val", int'(min_val), m_min);
        check("max_val", int'(max_val), m_max);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        enable     = 1'b1;
        clear      = 1'b0;
        din        = '0;
        din_pulse  = 1'b0;
        dout_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) step();
        rst_n = 1'b1;
        check("rst_level", int'(fifo_level), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_dout", int'(dout), 0);

        // Three pushes, no drain
        din_pulse = 1'b1;
        din = -16'sd5; step();
        din = 16'sd3;  step();
        din = 16'sd7;  step();
        din_pulse = 1'b0;
        step();
        check("t1_level", int'(fifo_level), 3);
        check("t1_dout", int'(dout), -5);
        check("t1_valid", int'(dout_valid), 1);
        check("t1_min", int'(min_val), -5);
        check("t1_max", int'(max_val), 7);

        // Drain in order
        dout_ready = 1'b1;
        check("t2_d0", int'(dout), -5); step();
        check("t2_d1", int'(dout), 3);  step();
        check("t2_d2", int'(dout), 7);  step();
        check("t2_valid", int'(dout_valid), 0);
        check("t2_level", int'(fifo_level), 0);
        dout_ready = 1'b0;

        // Overfill by four
        din_pulse = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 16'(100 + i);
            step();
        end
        din_pulse = 1'b0;
        check("t3_level", int'(fifo_level), 16);
        check("t3_ovf", int'(overflow), 1);
        check("t3_drops", int'(drop_cnt), 4);

        // Full with simultaneous push and pop
        din = 16'sd999; din_pulse = 1'b1; dout_ready = 1'b1;
        step();
        din_pulse = 1'b0;
        check("t4_drops", int'(drop_cnt), 4);
        for (int i = 0; i < 16; i++) begin
            check("t4_drain", int'(dout), (i < 15) ? 101 + i : 999);
            step();
        end
        dout_ready = 1'b0;
        check("t4_level", int'(fifo_level), 0);

        // Disabled capture, then clear with a coincident pulse
        din_pulse = 1'b1;
        din = -16'sd300; step();
        din = 16'sd42;   step();
        enable = 1'b0;
        repeat (5) step();
        check("t5_level", int'(fifo_level), 2);
        check("t5_drops", int'(drop_cnt), 4);
        enable = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; din_pulse = 1'b0;
        check("t5_clr_level", int'(fifo_level), 0);
        check("t5_clr_ovf", int'(overflow), 0);
        check("t5_clr_drops", int'(drop_cnt), 0);
        check("t5_clr_min", int'(min_val), 0);
        check("t5_clr_max", int'(max_val), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            din_pulse  = ($urandom_range(0, 2) != 0);
            dout_ready = ($urandom_range(0, 3) < ((i / 500) % 4));
            clear      = ($urandom_range(0, 299) == 0);
            din        = 16'($urandom);
            step();
        end
        idle_inputs();
        clear = 1'b1; step(); clear = 1'b0;

        // Saturating drop counter
        din_pulse = 1'b1;
        for (int i = 0; i < 316; i++) begin
            din = 16'($urandom);
            step();
        end
        check("t6_drops", int'(drop_cnt), 255);
        check("t6_level", int'(fifo_level), 16);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("t7_level", int'(fifo_level), 0);
        check("t7_valid", int'(dout_valid), 0);
        check("t7_dout", int'(dout), 0);
        check("t7_ovf", int'(overflow), 0);
        check("t7_drops", int'(drop_cnt), 0);
        check("t7_min", int'(min_val), 0);
        check("t7_max", int'(max_val), 0);
        @(negedge clk);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/moving_average_collector.md
Name: moving_average_collector

Overview:
Consumer end of the moving-average filter output interface. Captures each `dout`/`output_pulse` result from the filter into a show-ahead FIFO and presents results downstream on a valid/ready handshake. The filter cannot be back-pressured, so the block also flags and counts dropped results. It tracks the running min/max of accepted results for debug and status readout.

Parameters:
DEPTH, 16, FIFO entries; power of 2, at least 2.
AW, 4, address width; must equal log2(DEPTH).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
enable  in  1  capture enable; when low, incoming pulses are ignored
clear  in  1  synchronous clear of FIFO, flags, counters and min/max
din  in  16  signed result from filter `dout`
din_pulse  in  1  filter `output_pulse`; one-cycle valid strobe
dout  out  16  signed head-of-FIFO result
dout_valid  out  1  FIFO not empty
dout_ready  in  1  downstream accept
fifo_level  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; a result was dropped because the FIFO was full
drop_cnt  out  8  count of dropped results, saturates at 255
min_val  out  16  signed minimum of accepted results
max_val  out  16  signed maximum of accepted results

Behaviour:
- Reset (async, `rst_n`=0): write/read pointers=0, `fifo_level`=0, `dout_valid`=0, `dout`=0, `overflow`=0, `drop_cnt`=0, `min_val`=0, `max_val`=0, internal `seen_first`=0.
- Push: occurs when `enable`=1, `din_pulse`=1 and (level<DEPTH, or a pop occurs in the same cycle). `din` is written at the write pointer. Pointer wraps modulo DEPTH.
- Pop: occurs when `dout_valid`=1 and `dout_ready`=1. The read pointer advances with wrap.
- Show-ahead: `dout` always equals the head entry. A push into an empty FIFO raises `dout_valid` on the next edge (1-cycle latency). `dout` is 0 while empty.
- Level update: push only -> +1; pop only -> -1; push and pop together -> unchanged.
- Full with simultaneous push and pop: both are accepted, no drop.
- Empty with `din_pulse` and `dout_ready` together: push only. No pop, because `dout_valid` was 0.
- Drop: occurs when `enable`=1, `din_pulse`=1, level==DEPTH and no pop. On a drop:
  - the data is discarded;
  - `overflow` is set to 1;
  - `drop_cnt` increments, saturating at 255.
- `enable`=0: `din_pulse` is ignored and not counted as a drop. Draining via `dout_ready` continues normally.
- Min/max:
  - On each accepted push, if `seen_first`=0, set `min_val`=`max_val`=`din` and `seen_first`=1.
  - Otherwise use signed compare: `min_val`=min(`min_val`,`din`) and `max_val`=max(`max_val`,`din`).
  - Dropped samples do not update min/max.
- `clear`=1 (synchronous):
  - Same effect as reset on all state. Pointers, level, flags, counters and min/max return to reset values.
  - `clear` has priority over push and pop in the same cycle; that cycle's `din_pulse` is discarded and not counted as a drop.
- Reset mid-operation: all state returns to reset values immediately. Stored data is lost and `dout_valid` drops asynchronously.
- All outputs are registered except `dout` and `dout_valid`. These are combinational from the registered pointers, level and memory, so there is no comb path from `dout_ready`.

Test Plan:
- Reset then push -5, 3, 7 on separate `din_pulse` with `dout_ready`=0 -> `fifo_level`=3, `dout`=-5, `dout_valid`=1, `min_val`=-5, `max_val`=7.
- Drain with `dout_ready`=1 -> `dout` is -5, 3, 7 on successive cycles, then `dout_valid`=0 and `fifo_level`=0.
- DEPTH=16: push 20 results with `dout_ready`=0 -> `fifo_level`=16, `overflow`=1, `drop_cnt`=4; drained data is the first 16 values in order.
- With FIFO full, assert `din_pulse` and `dout_ready` in the same cycle -> no drop (`drop_cnt` unchanged), level stays 16, new value lands at the tail.
- `enable`=0 with 5 pulses -> level unchanged, `drop_cnt` unchanged. Then `clear`=1 with a coincident `din_pulse` -> level=0, `overflow`=0, `drop_cnt`=0, `min_val`=`max_val`=0.
- Write 300 drops while full -> `drop_cnt` saturates at 255. Assert `rst_n`=0 mid-stream -> all outputs 0 with no clock edge required.
